// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan controller.
// Latency: n/a (constants and elaboration-time helpers only).
// Backpressure: n/a.
package seg_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low {g,f,e,d,c,b,a} patterns, indexed by hex nibble.
    localparam logic [6:0] HEX_SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/seg_hex_enc.sv
// Hex nibble to active-low seven-segment pattern.
// Latency: combinational.
// Backpressure: none.
module seg_hex_enc
    import seg_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg_n
);

    assign seg_n = HEX_SEG[nib];

endmodule

// File: rtl/seg_scan_ctrl.sv
// 8-digit seven-segment scan controller with tear-free frame-boundary update.
// Latency: outputs registered; seg_n/dp_n change on the same edge as sel.
// Backpressure: none; load is a level strobe, latest capture wins until the frame wrap.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int CLK_HZ    = 100_000_000,
    parameter int SCAN_HZ   = 1_000,
    parameter int BLANK_CYC = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [31:0] value,
    input  logic [7:0]  dp_in,
    input  logic [7:0]  digit_en,
    input  logic        blank_lz,
    output logic [2:0]  sel,
    output logic [6:0]  seg_n,
    output logic        dp_n,
    output logic        frame_tick,
    output logic        upd_pending
);

    localparam int DIV = CLK_HZ / SCAN_HZ;
    localparam int PW  = (clog2(DIV) < 1) ? 1 : clog2(DIV);
    localparam int BW  = (clog2(BLANK_CYC + 1) < 1) ? 1 : clog2(BLANK_CYC + 1);
    localparam logic [PW-1:0] PRESC_MAX  = PW'(DIV - 1);
    localparam logic [BW-1:0] BLANK_INIT = BW'(BLANK_CYC);

    logic [PW-1:0] presc;
    logic [BW-1:0] blank_cnt;
    logic [31:0]   shadow;
    logic [31:0]   disp_val;
    logic [7:0]    shadow_dp;
    logic [7:0]    disp_dp;

    logic          wrap;
    logic          frame_wrap;
    logic          commit;
    logic [2:0]    sel_nx;
    logic [BW-1:0] blank_nx;
    logic [31:0]   disp_val_nx;
    logic [7:0]    disp_dp_nx;
    logic [3:0]    nib;
    logic [31:0]   upper;
    logic          lz_dark;
    logic          en_dark;
    logic          blank_dark;
    logic [6:0]    enc_seg;
    logic [6:0]    seg_nx;
    logic          dp_nx;

    seg_hex_enc u_enc (
        .nib   (nib),
        .seg_n (enc_seg)
    );

    // Everything below looks at post-edge sel/display so outputs never skew against sel.
    always_comb begin
        wrap        = (presc == PRESC_MAX);
        frame_wrap  = wrap && (sel == 3'd7);
        commit      = frame_wrap && upd_pending;
        sel_nx      = wrap ? sel + 3'd1 : sel;
        disp_val_nx = commit ? shadow : disp_val;
        disp_dp_nx  = commit ? shadow_dp : disp_dp;

        blank_nx = '0;
        if (wrap) begin
            blank_nx = BLANK_INIT;
        end else if (blank_cnt != '0) begin
            blank_nx = blank_cnt - BW'(1);
        end

        nib        = disp_val_nx[{sel_nx, 2'b00} +: 4];
        upper      = disp_val_nx >> {sel_nx, 2'b00};
        lz_dark    = blank_lz && (sel_nx != 3'd0) && (upper == 32'h0);
        en_dark    = !digit_en[sel_nx];
        blank_dark = (blank_nx != '0);

        seg_nx = (blank_dark || en_dark || lz_dark) ? SEG_BLANK : enc_seg;
        dp_nx  = (blank_dark || en_dark) ? 1'b1 : ~disp_dp_nx[sel_nx];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc       <= '0;
            sel         <= 3'd0;
            blank_cnt   <= BLANK_INIT;
            shadow      <= 32'h0;
            shadow_dp   <= 8'h0;
            disp_val    <= 32'h0;
            disp_dp     <= 8'h0;
            upd_pending <= 1'b0;
            seg_n       <= SEG_BLANK;
            dp_n        <= 1'b1;
            frame_tick  <= 1'b0;
        end else begin
            presc      <= wrap ? '0 : presc + PW'(1);
            sel        <= sel_nx;
            blank_cnt  <= blank_nx;
            disp_val   <= disp_val_nx;
            disp_dp    <= disp_dp_nx;
            seg_n      <= seg_nx;
            dp_n       <= dp_nx;
            frame_tick <= frame_wrap;
            // A load on the commit edge lands in shadow after the old shadow was taken.
            if (load) begin
                shadow      <= value;
                shadow_dp   <= dp_in;
                upd_pending <= 1'b1;
            end else if (commit) begin
                upd_pending <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: per-cycle expectations from a frame-level model.
module tb_seg_scan_ctrl;

    localparam int CLK_HZ    = 16;
    localparam int SCAN_HZ   = 2;
    localparam int BLANK_CYC = 2;
    localparam int DIV       = CLK_HZ / SCAN_HZ;
    localparam int FRAME     = DIV * 8;

    localparam logic [6:0] HEX [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic        clk;
    logic        rst_n;
    logic        load;
    logic [31:0] value;
    logic [7:0]  dp_in;
    logic [7:0]  digit_en;
    logic        blank_lz;
    logic [2:0]  sel;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic        frame_tick;
    logic        upd_pending;

    seg_scan_ctrl #(
        .CLK_HZ    (CLK_HZ),
        .SCAN_HZ   (SCAN_HZ),
        .BLANK_CYC (BLANK_CYC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (load),
        .value       (value),
        .dp_in       (dp_in),
        .digit_en    (digit_en),
        .blank_lz    (blank_lz),
        .sel         (sel),
        .seg_n       (seg_n),
        .dp_n        (dp_n),
        .frame_tick  (frame_tick),
        .upd_pending (upd_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [12:0] exp_q [$];

    // Model: n = clock edges since reset release; the display changes only on frame boundaries.
    int          n;
    logic [31:0] m_shadow;
    logic [31:0] m_disp;
    logic [7:0]  m_sdp;
    logic [7:0]  m_ddp;
    logic        m_pend;
    logic [7:0]  en_r;
    logic        lz_r;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at t=%0t: got %0h, expected %0h", name, $time, got, exp);
        end
    endtask

    function automatic logic [12:0] expect_out();
        int         digit;
        logic       dark;
        logic       tick;
        logic       lead;
        logic [6:0] sg;
        logic       dp;
        logic [3:0] nb;
        digit = (n / DIV) % 8;
        dark  = (n % DIV) < BLANK_CYC;
        tick  = (n > 0) && (n % FRAME == 0);
        lead  = 1'b1;
        for (int j = digit; j < 8; j++) begin
            nb = m_disp[4*j +: 4];
            if (nb != 4'h0) lead = 1'b0;
        end
        nb = m_disp[4*digit +: 4];
        if (dark || !en_r[digit]) begin
            sg = 7'h7F;
            dp = 1'b1;
        end else begin
            dp = !m_ddp[digit];
            sg = (lz_r && digit != 0 && lead) ? 7'h7F : HEX[nb];
        end
        return {3'(digit), sg, dp, tick, m_pend};
    endfunction

    task automatic step(input logic ld, input logic [31:0] v, input logic [7:0] d);
        load     = ld;
        value    = v;
        dp_in    = d;
        digit_en = en_r;
        blank_lz = lz_r;
        n++;
        if (n % FRAME == 0 && m_pend) begin
            m_disp = m_shadow;
            m_ddp  = m_sdp;
            m_pend = 1'b0;
        end
        if (ld) begin
            m_shadow = v;
            m_sdp    = d;
            m_pend   = 1'b1;
        end
        exp_q.push_back(expect_out());
        @(negedge clk);
    endtask

    task automatic idle(input int k);
        repeat (k) step(1'b0, $urandom, 8'($urandom));
    endtask

    task automatic model_reset();
        n        = 0;
        m_shadow = 32'h0;
        m_disp   = 32'h0;
        m_sdp    = 8'h0;
        m_ddp    = 8'h0;
        m_pend   = 1'b0;
    endtask

    task automatic reset_checks();
        chk("rst_sel", 32'(sel), 32'h0);
        chk("rst_seg_n", 32'(seg_n), 32'h7F);
        chk("rst_dp_n", 32'(dp_n), 32'h1);
        chk("rst_frame_tick", 32'(frame_tick), 32'h0);
        chk("rst_upd_pending", 32'(upd_pending), 32'h0);
    endtask

    // Called at a negedge; reset drops mid-dwell and is released one clock later.
    task automatic mid_reset();
        load  = 1'b0;
        rst_n = 1'b0;
        #1;
        reset_checks();
        model_reset();
        exp_q.push_back(expect_out());
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [12:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("scan{sel,seg_n,dp_n,tick,pend}",
                    32'({sel, seg_n, dp_n, frame_tick, upd_pending}), 32'(e));
            end
        end
    end

    initial begin
        rst_n    = 1'b0;
        load     = 1'b0;
        value    = 32'h0;
        dp_in    = 8'h0;
        en_r     = 8'hFF;
        lz_r     = 1'b0;
        digit_en = en_r;
        blank_lz = lz_r;
        model_reset();
        repeat (2) @(negedge clk);
        reset_checks();
        rst_n = 1'b1;

        // Free run on zero display.
        idle(2 * FRAME);

        // Mid-frame load becomes visible from digit 0 of the next frame.
        idle(20);
        step(1'b1, 32'h89AB_CDEF, 8'h01);
        idle(2 * FRAME + 5);

        // Leading-zero suppression.
        lz_r = 1'b1;
        step(1'b1, 32'h0000_0F00, 8'h00);
        idle(2 * FRAME);
        step(1'b1, 32'h0000_0000, 8'h00);
        idle(2 * FRAME);
        lz_r = 1'b0;

        // Two loads in one frame: only the later one is ever shown.
        while (n % FRAME != 3) idle(1);
        step(1'b1, 32'h1111_1111, 8'h00);
        idle(5);
        step(1'b1, 32'h2222_2222, 8'h00);
        idle(2 * FRAME);

        // Load coincident with the commit edge.
        while (n % FRAME != 10) idle(1);
        step(1'b1, 32'h0000_0005, 8'h00);
        while ((n + 1) % FRAME != 0) idle(1);
        step(1'b1, 32'h0000_0007, 8'h00);
        idle(2 * FRAME + 5);

        // Randomized loads, enables and zero blanking.
        for (int f = 0; f < 8; f++) begin
            while (n % FRAME != 0) idle(1);
            en_r = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'hFF;
            lz_r = 1'($urandom);
            for (int c = 0; c < FRAME; c++) begin
                if ($urandom_range(0, 23) == 0)
                    step(1'b1, $urandom >> $urandom_range(0, 31), 8'($urandom));
                else
                    idle(1);
            end
        end
        en_r = 8'hFF;
        lz_r = 1'b0;

        // Asynchronous reset mid-dwell of digit 5 with an update pending.
        step(1'b1, 32'hDEAD_BEEF, 8'hFF);
        while (!((n / DIV) % 8 == 5 && n % DIV == 3)) idle(1);
        mid_reset();
        idle(FRAME + 10);

        load = 1'b0;
        @(posedge clk);
        #2;
        chk("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
